// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the 5-stage RV32I core.
//   * Result-source encodings for the writeback mux.
//   * hz_state_t: sequencing state of hazard_unit.
// Revision: 1.0 - initial release
// ============================================================================
package core_pkg;

   localparam logic [1:0] ALU_RESULT = 2'b00;
   localparam logic [1:0] MEM_TO_REG = 2'b01;
   localparam logic [1:0] PC_PLUS    = 2'b10;
   localparam logic [1:0] LUI_AUIPC  = 2'b11;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MULDIV   = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// hazard_detect
// ----------------------------------------------------------------------------
// Combinational load-use comparator. Flags when the instruction in decode
// reads a register that the load now in execute is about to write.
// Ports:
//   fetch_rs1_i/fetch_rs2_i         source registers of the decode instruction
//   fetch_uses_rs1_i/_rs2_i         the decode instruction really reads them
//   decode_rd_i                     destination of the execute instruction
//   decode_result_src_i             result source of the execute instruction
//   decode_regfile_wr_enable_i      execute instruction writes the regfile
//   load_use_o                      a one-bubble load-use hazard exists
// Revision: 1.0 - initial release
// ============================================================================
module hazard_detect (
   input  logic [4:0] fetch_rs1_i,
   input  logic [4:0] fetch_rs2_i,
   input  logic       fetch_uses_rs1_i,
   input  logic       fetch_uses_rs2_i,
   input  logic [4:0] decode_rd_i,
   input  logic [1:0] decode_result_src_i,
   input  logic       decode_regfile_wr_enable_i,
   output logic       load_use_o
);
   import core_pkg::*;

   logic w_is_load;
   logic w_rs1_hit;
   logic w_rs2_hit;

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   assign w_is_load = (decode_result_src_i == MEM_TO_REG) && decode_regfile_wr_enable_i
                      && (decode_rd_i != 5'd0);
   assign w_rs1_hit = fetch_uses_rs1_i && (fetch_rs1_i == decode_rd_i);
   assign w_rs2_hit = fetch_uses_rs2_i && (fetch_rs2_i == decode_rd_i);
   assign load_use_o = w_is_load && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// hazard_unit
// ----------------------------------------------------------------------------
// Pipeline sequencing controller: per-cycle stall/flush decisions for
// load-use, taken control flow, multi-cycle mul/div and wait-stated data
// memory, plus a stall-cycle performance counter.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   fetch_*                            decode-stage operand usage
//   decode_*                           execute-stage instruction attributes
//   muldiv_done                        mul/div result valid (pulse)
//   execute_pc_src                     jump / taken branch resolved in execute
//   mem_req, datamem_ready             mem-stage access handshake
//   muldiv_start                       one-cycle start to mul/div unit
//   fetch/decode/execute_stall         hold pipeline registers
//   fetch/decode_flush                 bubble pipeline registers
//   mem_timeout                        sticky: a memory wait ran too long
//   stall_count                        cycles with fetch_stall high
// Revision: 1.0 - initial release
// ============================================================================
module hazard_unit #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       fetch_rs1,
   input  logic [4:0]       fetch_rs2,
   input  logic             fetch_uses_rs1,
   input  logic             fetch_uses_rs2,
   input  logic [4:0]       decode_rd,
   input  logic [1:0]       decode_result_src,
   input  logic             decode_regfile_wr_enable,
   input  logic             decode_muldiv,
   input  logic             muldiv_done,
   input  logic             execute_pc_src,
   input  logic             mem_req,
   input  logic             datamem_ready,
   output logic             muldiv_start,
   output logic             fetch_stall,
   output logic             decode_stall,
   output logic             execute_stall,
   output logic             fetch_flush,
   output logic             decode_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);
   import core_pkg::*;

   localparam int unsigned     MW_W     = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;
   localparam logic [MW_W-1:0] MW_LIMIT = MW_W'(MEM_TIMEOUT);

   hz_state_t        state_q, state_d;
   logic             done_pending_q, done_pending_d;
   logic             in_mul_q, in_mul_d;       // MEM_WAIT was entered with mul/div in flight
   logic             issued_q, issued_d;       // instruction in execute already got its start
   logic [MW_W-1:0]  mw_cnt_q, mw_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cnt_q;

   logic w_load_use;
   logic w_mem_wait;
   logic w_run_eval;

   hazard_detect u_detect (
      .fetch_rs1_i                (fetch_rs1),
      .fetch_rs2_i                (fetch_rs2),
      .fetch_uses_rs1_i           (fetch_uses_rs1),
      .fetch_uses_rs2_i           (fetch_uses_rs2),
      .decode_rd_i                (decode_rd),
      .decode_result_src_i        (decode_result_src),
      .decode_regfile_wr_enable_i (decode_regfile_wr_enable),
      .load_use_o                 (w_load_use)
   );

   assign w_mem_wait = mem_req && !datamem_ready;

   always_comb begin
      state_d        = state_q;
      done_pending_d = done_pending_q;
      in_mul_d       = in_mul_q;
      mw_cnt_d       = mw_cnt_q;
      mem_timeout_d  = mem_timeout_q;
      muldiv_start   = 1'b0;
      fetch_stall    = 1'b0;
      decode_stall   = 1'b0;
      execute_stall  = 1'b0;
      fetch_flush    = 1'b0;
      decode_flush   = 1'b0;
      w_run_eval     = 1'b0;

      case (state_q)
         MULDIV: begin
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
            if (w_mem_wait) begin
               execute_stall  = 1'b1;
               state_d        = MEM_WAIT;
               mw_cnt_d       = '0;
               in_mul_d       = 1'b1;
               done_pending_d = muldiv_done;
            end else if (muldiv_done) begin
               state_d = RUN;
            end
         end
         MEM_WAIT: begin
            if (!datamem_ready) begin
               fetch_stall   = 1'b1;
               decode_stall  = 1'b1;
               execute_stall = 1'b1;
               if (muldiv_done) begin
                  done_pending_d = 1'b1;
               end
               if (mw_cnt_q != '1) begin
                  mw_cnt_d = mw_cnt_q + 1'b1;
               end
               if (mw_cnt_d >= MW_LIMIT) begin
                  mem_timeout_d = 1'b1;
               end
            end else begin
               done_pending_d = 1'b0;
               in_mul_d       = 1'b0;
               if (in_mul_q && !done_pending_q && !muldiv_done) begin
                  // Mul/div still busy: EX/MEM takes a bubble, front end keeps waiting.
                  state_d      = MULDIV;
                  fetch_stall  = 1'b1;
                  decode_stall = 1'b1;
               end else begin
                  // Execute advances this cycle, so it is evaluated exactly like RUN.
                  state_d    = RUN;
                  w_run_eval = 1'b1;
               end
            end
         end
         default: begin
            state_d    = RUN;
            w_run_eval = 1'b1;
         end
      endcase

      if (w_run_eval) begin
         if (w_mem_wait) begin
            fetch_stall    = 1'b1;
            decode_stall   = 1'b1;
            execute_stall  = 1'b1;
            state_d        = MEM_WAIT;
            mw_cnt_d       = '0;
            in_mul_d       = 1'b0;
            done_pending_d = 1'b0;
         end else if (execute_pc_src) begin
            // Redirect kills the two younger instructions; any load-use stall is moot.
            fetch_flush  = 1'b1;
            decode_flush = 1'b1;
         end else if (decode_muldiv && !issued_q) begin
            muldiv_start = 1'b1;
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
            state_d      = MULDIV;
         end else if (w_load_use) begin
            fetch_stall  = 1'b1;
            decode_flush = 1'b1;
         end
      end

      // ID/EX reloads whenever decode is not held; that retires the started op.
      if (muldiv_start) begin
         issued_d = 1'b1;
      end else if (!decode_stall) begin
         issued_d = 1'b0;
      end else begin
         issued_d = issued_q;
      end

      if (rst) begin
         muldiv_start  = 1'b0;
         fetch_stall   = 1'b0;
         decode_stall  = 1'b0;
         execute_stall = 1'b0;
         fetch_flush   = 1'b1;
         decode_flush  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         done_pending_q <= 1'b0;
         in_mul_q       <= 1'b0;
         issued_q       <= 1'b0;
         mw_cnt_q       <= '0;
         mem_timeout_q  <= 1'b0;
         stall_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         done_pending_q <= done_pending_d;
         in_mul_q       <= in_mul_d;
         issued_q       <= issued_d;
         mw_cnt_q       <= mw_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         if (fetch_stall) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   assign mem_timeout = mem_timeout_q;
   assign stall_count = stall_cnt_q;

endmodule
`default_nettype wire
